reg_file_writer: RTL
====================

// Module: reg_file_writer
// PURPOSE
//  Write side of the 10 x 32-bit register file: accepts write-back requests from the
//  pipeline, buffers them in a small FIFO and retires them into the array when not stalled.
//  Also provides the registered read port (rd_reg -> rd_val, 1-cycle latency), forwarding
//  data that is still pending. Sits between the pipeline write-back stage and the
//  operand-fetch stage; the pipeline Stall signal gates retirement.
// PARAMETERS
//  NREGS   10  number of architectural registers
//  WIDTH   32  register data width
//  AW      4   register-index width; indices >= NREGS are out of range
//  DEPTH   2   pending-write FIFO depth (power of two, >= 2)
//  CNTW    8   width of drop counter
// PORTS
//  clk       in   1      clock, all state updates on posedge
//  rst_n     in   1      synchronous reset, active-low
//  wr_valid  in   1      write request valid
//  wr_ready  out  1      FIFO can accept; transfer when wr_valid && wr_ready
//  wr_reg    in   AW     destination register index
//  wr_data   in   WIDTH  write data
//  stall     in   1      1 = hold FIFO head, no array write this cycle
//  rd_reg    in   AW     read index, sampled on posedge
//  rd_val    out  WIDTH  registered read data
//  busy      out  1      FIFO non-empty
//  drop_cnt  out  CNTW   saturating count of dropped out-of-range writes
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): array cleared to 0, FIFO emptied (pending writes
//   discarded), rd_val=0, drop_cnt=0. Outputs after reset: wr_ready=1, busy=0.
//  wr_ready = !full, derived from the registered count only; no same-cycle bypass, so
//   when full, a pop in the same cycle does not raise wr_ready.
//  Push: wr_valid && wr_ready -> {wr_reg,wr_data} enters FIFO tail at posedge.
//  Pop: !stall && !empty -> head retired at posedge: if head.reg < NREGS,
//   array[head.reg] <= head.data; else drop_cnt <= drop_cnt+1 (saturates at all-ones).
//  Push and pop in the same cycle: count unchanged, both take effect.
//  Latency: accepted in cycle N -> earliest array update at posedge ending cycle N+1.
//  FIFO order preserved; same-register writes retire in acceptance order.
//  stall=1: FIFO holds, pushes continue until full; array is unchanged.
//  Read: at posedge rd_val <= 0 if rd_reg >= NREGS; else the youngest FIFO entry whose
//   reg == rd_reg (including the entry popped this cycle), else array[rd_reg]. A push in the
//   same cycle is NOT forwarded (visible to a read issued in the next cycle).
//  Pointers wrap modulo DEPTH; count is kept in $clog2(DEPTH)+1 bits.
// STRUCTURE
//  Shared package rf_pkg: NREGS, WIDTH, AW constants; typedef wr_req_t {reg, data}.
//  Sub-module rf_wr_fifo (DEPTH entries of wr_req_t, push/pop/full/empty, plus an
//   exposed entry vector and valid mask for the forwarding search). Array, retire logic,
//   forwarding mux and drop counter live in reg_file_writer.
// TESTING
//  1 Reset, then write r3=0xDEADBEEF with stall=0; read r3 two cycles later -> 0xDEADBEEF;
//    busy high for exactly 1 cycle.
//  2 stall=1; push r1=0x11, r1=0x22 -> wr_ready=0 after 2nd push; rd r1 -> 0x22 (forward);
//    array r1 is still 0; release stall -> retire in order, final r1=0x22.
//  3 Full FIFO with stall=0 and wr_valid held -> wr_ready low 1 cycle, no lost or dup write.
//  4 Write r12=0x55 -> array unchanged, drop_cnt 0->1; 300 such writes -> drop_cnt=0xFF.
//  5 rd_reg=10 -> rd_val=0 regardless of pending writes.
//  6 stall=1, two writes pending, assert rst_n=0 for 1 cycle -> FIFO empty, all regs 0,
//    wr_ready=1 afterwards.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the register-file write side.
//   NREGS  - number of architectural registers
//   WIDTH  - register data width
//   AW     - register index width (indices >= NREGS are out of range)
//   DEPTH  - pending-write FIFO depth (power of two, >= 2)
//   CNTW   - width of the dropped-write counter
//   wr_req_t - one pending write: destination index plus data
package rf_pkg;

  localparam int NREGS = 10;
  localparam int WIDTH = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int CNTW  = 8;

  // NREGS as an index-width value so range checks compare like widths.
  localparam logic [AW-1:0] NREGS_IDX = AW'(NREGS);

  // "reg" is a keyword, so the destination field is called dst.
  typedef struct packed {
    logic [AW-1:0]    dst;
    logic [WIDTH-1:0] data;
  } wr_req_t;

  // True when an index addresses a real register.
  function automatic logic in_range(input logic [AW-1:0] idx);
    return idx < NREGS_IDX;
  endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// rf_wr_fifo: small FIFO of pending register writes.
//   clk, rst_n  - clock, synchronous active-low reset (empties the FIFO)
//   push        - enqueue push_data at the tail (ignored when full)
//   push_data   - entry to enqueue
//   pop         - dequeue the head (ignored when empty)
//   head        - current head entry
//   full, empty - occupancy flags, from the registered count only
//   entries     - all slots in age order, entries[0] = head (oldest)
//   valid_mask  - valid_mask[i] set when entries[i] holds a pending write
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wr_req_t               push_data,
  input  logic                  pop,
  output wr_req_t               head,
  output logic                  full,
  output logic                  empty,
  output wr_req_t [DEPTH-1:0]   entries,
  output logic    [DEPTH-1:0]   valid_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wr_req_t        mem [DEPTH];
  logic  [PW-1:0] wr_ptr;
  logic  [PW-1:0] rd_ptr;
  logic  [CW-1:0] count;

  logic push_ok;
  logic pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Age-ordered view for the forwarding search; higher index = younger.
  always_comb begin
    entries    = '0;
    valid_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries[i]    = mem[rd_ptr + PW'(i)];
      valid_mask[i] = (CW'(i) < count);
    end
  end

endmodule

// File: rtl/reg_file_writer.sv
// reg_file_writer: write side and registered read port of the register file.
//   clk, rst_n - clock, synchronous active-low reset
//   wr_valid   - write request valid
//   wr_ready   - FIFO can accept a request
//   wr_reg     - destination register index
//   wr_data    - write data
//   stall      - holds the FIFO head; no array write while high
//   rd_reg     - read index, sampled on posedge
//   rd_val     - registered read data (1-cycle latency, forwards pending writes)
//   busy       - pending writes exist
//   drop_cnt   - saturating count of retired out-of-range writes
//
// Handshake: a request transfers on a posedge where wr_valid && wr_ready are
// both high. wr_ready depends only on registered FIFO occupancy (never on
// wr_valid or on a same-cycle retire), so a full FIFO holds wr_ready low for
// that whole cycle; the requester keeps wr_reg/wr_data stable until transfer.
module reg_file_writer
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_reg,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             stall,
  input  logic [AW-1:0]    rd_reg,
  output logic [WIDTH-1:0] rd_val,
  output logic             busy,
  output logic [CNTW-1:0]  drop_cnt
);

  logic [WIDTH-1:0] regs [NREGS];

  wr_req_t              push_data;
  wr_req_t              head;
  wr_req_t [DEPTH-1:0]  entries;
  logic    [DEPTH-1:0]  valid_mask;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  assign wr_ready       = !full;
  assign busy           = !empty;
  assign push           = wr_valid && wr_ready;
  assign pop            = !stall && !empty;
  assign push_data.dst  = wr_reg;
  assign push_data.data = wr_data;

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .entries    (entries),
    .valid_mask (valid_mask)
  );

  // Read data for the next edge. The search runs over the FIFO contents as
  // they stand before the edge, so the entry retiring this cycle is still
  // seen and a request pushed this cycle is not. Scanning oldest to youngest
  // lets the youngest match win.
  logic [WIDTH-1:0] rd_next;

  always_comb begin
    rd_next = '0;
    if (in_range(rd_reg)) begin
      rd_next = regs[rd_reg];
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_mask[i] && (entries[i].dst == rd_reg)) begin
          rd_next = entries[i].data;
        end
      end
    end
  end

  // Retire: write the head into the array, or count it as dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      drop_cnt <= '0;
    end else if (pop) begin
      if (in_range(head.dst)) begin
        regs[head.dst] <= head.data;
      end else if (drop_cnt != {CNTW{1'b1}}) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_val <= '0;
    else        rd_val <= rd_next;
  end

endmodule
